// File: rtl/line_buf_fill.sv
// line_buf_fill: raster feeder for the 3x3 convolution stage.
// Keeps the three most recent lines in three circular line buffers and
// alternates between loading a line and serving one output row, so the
// consumer never reads a buffer while it is being overwritten.
// LB1/LB2/LB3 are zero-latency windows {buf[a], buf[a+1], buf[a+2]} of
// buffers 0/1/2; k names the buffer holding the top row.
// Optional: define LBF_FRAME_DONE_EN to add the frame_done pulse output.
module line_buf_fill #(
  parameter int IMG_W = 100,
  parameter int IMG_H = 100,
  parameter int N_WIN = 97
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        rd_en,
  input  logic [6:0]  rd_addr,
  output logic [23:0] LB1,
  output logic [23:0] LB2,
  output logic [23:0] LB3,
  output logic        data_valid,
`ifdef LBF_FRAME_DONE_EN
  output logic        frame_done,
`endif
  output logic [1:0]  k
);

  localparam int RW = (IMG_H > 4) ? $clog2(IMG_H) : 2;

  localparam logic [6:0]    LAST_COL = 7'(IMG_W - 1);
  localparam logic [6:0]    LAST_WIN = 7'(N_WIN - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 3);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic [1:0] {
    S_FILL,
    S_SERVE,
    S_REFILL,
    S_FRAME_END
  } state_t;

  state_t        state;
  logic [1:0]    wr_sel;
  logic [6:0]    wr_col;
  logic [1:0]    fill_cnt;
  logic [RW-1:0] row_cnt;

  logic [7:0]    mem [3][IMG_W];

  logic          accept;
  logic          wr_en;
  logic [1:0]    wr_buf;
  logic [6:0]    a1;
  logic [6:0]    a2;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Write handshake and target buffer: REFILL overwrites the oldest line (k).
  always_comb begin
    accept = pix_valid & pix_ready;
    wr_en  = accept & rst;
    wr_buf = (state == S_REFILL) ? k : wr_sel;
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_FILL;
      pix_ready  <= 1'b1;
      data_valid <= 1'b0;
      k          <= '0;
      wr_sel     <= '0;
      wr_col     <= '0;
      fill_cnt   <= '0;
      row_cnt    <= '0;
`ifdef LBF_FRAME_DONE_EN
      frame_done <= 1'b0;
`endif
    end else begin
`ifdef LBF_FRAME_DONE_EN
      frame_done <= 1'b0;
`endif
      case (state)
        S_FILL: begin
          if (accept) begin
            if (wr_col == LAST_COL) begin
              wr_col   <= '0;
              fill_cnt <= fill_cnt + 2'd1;
              if (fill_cnt == 2'd2) begin
                wr_sel     <= '0;
                k          <= '0;
                data_valid <= 1'b1;
                pix_ready  <= 1'b0;
                state      <= S_SERVE;
              end else begin
                wr_sel <= inc3(wr_sel);
              end
            end else begin
              wr_col <= wr_col + 7'd1;
            end
          end
        end
        S_SERVE: begin
          if (rd_en && (rd_addr == LAST_WIN)) begin
            data_valid <= 1'b0;
            if (row_cnt == LAST_ROW) begin
              state <= S_FRAME_END;
`ifdef LBF_FRAME_DONE_EN
              frame_done <= 1'b1;
`endif
            end else begin
              row_cnt   <= row_cnt + ROW_ONE;
              pix_ready <= 1'b1;
              state     <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          if (accept) begin
            if (wr_col == LAST_COL) begin
              wr_col     <= '0;
              k          <= inc3(k);
              data_valid <= 1'b1;
              pix_ready  <= 1'b0;
              state      <= S_SERVE;
            end else begin
              wr_col <= wr_col + 7'd1;
            end
          end
        end
        S_FRAME_END: begin
          row_cnt   <= '0;
          fill_cnt  <= '0;
          wr_col    <= '0;
          wr_sel    <= '0;
          k         <= '0;
          pix_ready <= 1'b1;
          state     <= S_FILL;
        end
        default: begin
          state <= S_FILL;
        end
      endcase
    end
  end

  // Line storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_buf][wr_col] <= pix_in;
    end
  end

  // Zero-latency window reads from all three buffers.
  always_comb begin
    a1  = rd_addr + 7'd1;
    a2  = rd_addr + 7'd2;
    LB1 = {mem[0][rd_addr], mem[0][a1], mem[0][a2]};
    LB2 = {mem[1][rd_addr], mem[1][a1], mem[1][a2]};
    LB3 = {mem[2][rd_addr], mem[2][a1], mem[2][a2]};
  end

endmodule

// File: tb/tb_line_buf_fill.sv
// tb_line_buf_fill: directed + randomized bench for line_buf_fill.
// Reference model: three line arrays updated by line number (line L of the
// fill goes to buffer L, the refill after row r goes to buffer r mod 3).
module tb_line_buf_fill;

  localparam int W  = 100;
  localparam int H  = 100;
  localparam int NW = 97;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        rd_en = 1'b0;
  logic [6:0]  rd_addr = '0;
  logic [23:0] LB1;
  logic [23:0] LB2;
  logic [23:0] LB3;
  logic        data_valid;
  logic [1:0]  k;
`ifdef LBF_FRAME_DONE_EN
  logic        frame_done;
`endif

  always #5 clk = ~clk;

  line_buf_fill #(.IMG_W(W), .IMG_H(H), .N_WIN(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .LB1        (LB1),
    .LB2        (LB2),
    .LB3        (LB3),
    .data_valid (data_valid),
`ifdef LBF_FRAME_DONE_EN
    .frame_done (frame_done),
`endif
    .k          (k)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] m [3][W];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] win(input int b, input int a);
    return {m[b][a], m[b][a+1], m[b][a+2]};
  endfunction

  task automatic chk_windows(input string tag, input int a);
    chk($sformatf("%s_LB1@%0d", tag, a), {8'h0, LB1}, {8'h0, win(0, a)});
    chk($sformatf("%s_LB2@%0d", tag, a), {8'h0, LB2}, {8'h0, win(1, a)});
    chk($sformatf("%s_LB3@%0d", tag, a), {8'h0, LB3}, {8'h0, win(2, a)});
  endtask

  // Offer one pixel and wait (bounded) for it to be taken; b<0 skips the model.
  task automatic push(input logic [7:0] v, input int b, input int c);
    int n = 0;
    @(negedge clk);
    pix_valid = 1'b1;
    pix_in    = v;
    while (pix_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pix_ready_wait", {31'h0, pix_ready}, 32'd1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    if (b >= 0) m[b][c] = v;
  endtask

  // Load three lines; pattern=1 uses value (L*16+c)&FF, else random.
  task automatic fill_frame(input bit pattern);
    logic [7:0] v;
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < W; c++) begin
        v = pattern ? 8'((l * 16 + c) & 255) : 8'($urandom_range(0, 255));
        push(v, l, c);
      end
    end
    @(negedge clk);
    chk("fill_dv", {31'h0, data_valid}, 32'd1);
    chk("fill_k", {30'h0, k}, 32'd0);
    chk("fill_ready", {31'h0, pix_ready}, 32'd0);
  endtask

  // Check every in-contract window without strobing rd_en.
  task automatic sweep(input string tag);
    for (int a = 0; a <= W - 3; a++) begin
      @(negedge clk);
      rd_en   = 1'b0;
      rd_addr = 7'(a);
      #1;
      chk_windows(tag, a);
    end
  endtask

  // Consumer model: read windows 0..NW-1 with random idle gaps.
  task automatic serve_row(input int r);
    @(negedge clk);
    chk($sformatf("row%0d_dv", r), {31'h0, data_valid}, 32'd1);
    chk($sformatf("row%0d_k", r), {30'h0, k}, 32'(r % 3));
    for (int a = 0; a < NW; a++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        rd_en   = 1'b0;
        rd_addr = 7'($urandom_range(0, W - 3));
        #1;
        chk("gap_dv", {31'h0, data_valid}, 32'd1);
      end
      @(negedge clk);
      rd_en   = 1'b1;
      rd_addr = 7'(a);
      #1;
      chk_windows($sformatf("row%0d", r), a);
      @(posedge clk);
      #1;
      rd_en = 1'b0;
    end
    @(negedge clk);
    chk($sformatf("row%0d_done_dv", r), {31'h0, data_valid}, 32'd0);
    if (r != H - 3) begin
      chk($sformatf("row%0d_done_ready", r), {31'h0, pix_ready}, 32'd1);
    end else begin
      chk("frame_end_ready", {31'h0, pix_ready}, 32'd0);
`ifdef LBF_FRAME_DONE_EN
      chk("frame_done_pulse", {31'h0, frame_done}, 32'd1);
`endif
      @(negedge clk);
      chk("restart_ready", {31'h0, pix_ready}, 32'd1);
      chk("restart_k", {30'h0, k}, 32'd0);
      chk("restart_dv", {31'h0, data_valid}, 32'd0);
`ifdef LBF_FRAME_DONE_EN
      chk("frame_done_clear", {31'h0, frame_done}, 32'd0);
`endif
    end
  endtask

  // Refill the oldest buffer (r mod 3) with cnt random pixels, with read-side noise.
  task automatic refill(input int r, input int cnt);
    int b = r % 3;
    for (int c = 0; c < cnt; c++) begin
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = 7'(NW - 1);
      push(8'($urandom_range(0, 255)), b, c);
    end
    rd_en = 1'b0;
    if (cnt == W) begin
      @(negedge clk);
      chk($sformatf("refill%0d_dv", r), {31'h0, data_valid}, 32'd1);
      chk($sformatf("refill%0d_k", r), {30'h0, k}, 32'((r + 1) % 3));
      chk($sformatf("refill%0d_ready", r), {31'h0, pix_ready}, 32'd0);
    end
  endtask

  initial begin
    // Reset held with traffic offered, then released.
    pix_valid = 1'b1;
    pix_in    = 8'hAA;
    repeat (3) @(negedge clk);
    chk("rst_dv", {31'h0, data_valid}, 32'd0);
    chk("rst_k", {30'h0, k}, 32'd0);
`ifdef LBF_FRAME_DONE_EN
    chk("rst_frame_done", {31'h0, frame_done}, 32'd0);
`endif
    pix_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    chk("rel_ready", {31'h0, pix_ready}, 32'd1);
    chk("rel_dv", {31'h0, data_valid}, 32'd0);
    chk("rel_k", {30'h0, k}, 32'd0);

    // Partial line, then reset mid-stream: partial line is discarded.
    for (int c = 0; c < 40; c++) push(8'($urandom_range(0, 255)), 0, c);
    #2;
    rst       = 1'b0;
    pix_valid = 1'b1;
    pix_in    = 8'h55;
    #1;
    chk("midrst_dv", {31'h0, data_valid}, 32'd0);
    repeat (2) @(negedge clk);
    pix_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'h0, pix_ready}, 32'd1);
    chk("midrst_k", {30'h0, k}, 32'd0);

    // Initial fill with the documented pattern.
    fill_frame(1'b1);
    @(negedge clk);
    rd_addr = 7'd5;
    #1;
    chk("addr5_LB1", {8'h0, LB1}, 32'h00050607);
    chk("addr5_LB2", {8'h0, LB2}, 32'h00151617);
    chk("addr5_LB3", {8'h0, LB3}, 32'h00252627);

    // Backpressure: upstream keeps offering during SERVE.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pix_valid = 1'b1;
      pix_in    = 8'($urandom_range(0, 255));
      chk("bp_ready", {31'h0, pix_ready}, 32'd0);
      chk("bp_dv", {31'h0, data_valid}, 32'd1);
    end
    sweep("bp");
    pix_valid = 1'b0;

    // Row handoff, then the rest of the frame.
    serve_row(0);
    refill(0, W);
    sweep("handoff");
    for (int r = 1; r <= H - 3; r++) begin
      serve_row(r);
      if (r != H - 3) refill(r, W);
    end

    // Second frame: reset mid-REFILL after 50 pixels.
    fill_frame(1'b0);
    serve_row(0);
    refill(0, 50);
    #2;
    rst       = 1'b0;
    pix_valid = 1'b1;
    pix_in    = 8'h3C;
    #1;
    chk("refill_rst_dv", {31'h0, data_valid}, 32'd0);
    repeat (2) @(negedge clk);
    pix_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    chk("refill_rst_ready", {31'h0, pix_ready}, 32'd1);
    chk("refill_rst_k", {30'h0, k}, 32'd0);
    chk("refill_rst_dv2", {31'h0, data_valid}, 32'd0);
    fill_frame(1'b0);
    sweep("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/line_buf_fill.md
# line_buf_fill

Upstream feeder for the 3x3 convolution stage. Accepts a raster pixel stream, stores the three most recent image lines in three circular line buffers, and presents 3-pixel windows from each buffer at the consumer's read address. Also supplies the `k` rotation index that tells the consumer which buffer holds the top row. Alternates between filling buffers and serving one full output row, so the conv stage never sees a buffer being overwritten.

## Interface
- `IMG_W`, 100: pixels per line (≤128).
- `IMG_H`, 100: lines per frame (≥3).
- `N_WIN`, 97: windows read per served row; requires `N_WIN ≤ IMG_W-2`.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `pix_in` input 8: input pixel, unsigned.
- `pix_valid` input 1: `pix_in` valid.
- `pix_ready` output 1: pixel accepted on an edge where `pix_valid & pix_ready`.
- `rd_en` input 1: consumer read strobe.
- `rd_addr` input 7: window start column.
- `LB1`, `LB2`, `LB3` output 24: window from buffer 0/1/2, defined as `{buf[a], buf[a+1], buf[a+2]}` with `a = rd_addr`; leftmost pixel is in [23:16].
- `data_valid` output 1: three lines resident and the row is being served.
- `k` output 2: index (0..2) of the buffer holding the top row of the current window.
- `frame_done` output 1: present only with `LBF_FRAME_DONE_EN`.

## Operation
- Storage is 3×`IMG_W` bytes. `LBn` outputs are combinational reads of the registered array, with no read latency.
- Counters:
  - `wr_sel` (0..2): buffer being written.
  - `wr_col` (0..`IMG_W-1`): write column.
  - `fill_cnt` (0..3): lines loaded in FILL.
  - `row_cnt` (0..`IMG_H-3`): rows served in the frame.
- State machine:
  - **FILL**
    - `pix_ready=1`. Each accepted pixel writes `buf[wr_sel][wr_col]` and increments `wr_col`.
    - At `wr_col==IMG_W-1`: `wr_col←0`, `wr_sel←wr_sel+1 (mod 3)`, `fill_cnt+1`.
    - When the third line completes → SERVE with `k=0`, `wr_sel=0`.
  - **SERVE**
    - `data_valid=1`, `pix_ready=0`.
    - Row-done is the cycle where `rd_en==1 && rd_addr==N_WIN-1`.
    - On that edge `data_valid←0`. If `row_cnt==IMG_H-3` → FRAME_END; else `row_cnt+1` → REFILL.
  - **REFILL**
    - `pix_ready=1`. Writes one line into buffer `k` (the oldest), starting at `wr_col=0`.
    - On the last pixel: `k←k+1 (mod 3)` → SERVE.
  - **FRAME_END**
    - One cycle.
    - Clears `row_cnt`, `fill_cnt`, `wr_col`, `wr_sel`, `k` → FILL.
- `rd_en` or `rd_addr` activity outside SERVE is ignored.
- Pixels presented while `pix_ready=0` are not consumed; the upstream source holds them.
- `rd_addr+2 > IMG_W-1` is out of contract; the returned data is unspecified.

## Timing
- Reset (async assert, synchronous release) → FILL, with all of the following at 0:
  - `data_valid`, `k`, `frame_done`
  - all counters
- `pix_ready` reads 1 from the first cycle after reset release.
- Buffer contents are not cleared by reset.
- `data_valid` rises on the edge that accepts the last pixel of the third (FILL) or refilled (REFILL) line. It is visible the following cycle.
- `LBn` reflects a written pixel from the cycle after the write edge.
- `data_valid` and `LBn` stay stable for the whole SERVE state. The consumer samples them in any cycle while `rd_en=1`.
- From row-done, `pix_ready` is 1 in the next cycle (REFILL) or two cycles later (via FRAME_END → FILL).
- Per served row: `IMG_W` accepted pixels plus the consumer's row time. There is no overlap by design.
- Reset mid-operation: the state machine aborts immediately, a partial line is discarded, and the next frame starts from FILL.

## Configuration
- `LBF_FRAME_DONE_EN` defined:
  - Adds port `frame_done` output 1, reset 0.
  - Pulses high for exactly one cycle, in the FRAME_END cycle.
- `LBF_FRAME_DONE_EN` undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- **Reset**: hold `rst=0` mid-stream, release.
  - Next cycle: `pix_ready=1`, `data_valid=0`, `k=0`.
  - No writes during reset.
- **Initial fill**: stream 300 pixels with line L, column c holding value `(L*16+c)&8'hFF`.
  - `data_valid=1` after the 300th.
  - `k=0`.
  - `rd_addr=5` → `LB1=24'h050607`, `LB2=24'h151617`, `LB3=24'h252627`.
- **Backpressure**: `pix_valid` held high during SERVE.
  - `pix_ready=0` throughout.
  - `LBn` unchanged at all addresses.
- **Row handoff with conv-stage model**:
  - 97 reads (addresses 0..96).
  - Cycle after the addr-96 read: `data_valid=0`, `pix_ready=1`.
  - 100 new pixels overwrite buffer 0.
  - `data_valid=1`, `k=1`, and `LB1` returns the new line.
- **Full 100×100 frame**:
  - 98 rows served.
  - `k` sequence 0,1,2,0,…,1.
  - One `frame_done` pulse (with macro).
  - Then FILL restarts with `k=0`.
- **Reset mid-REFILL** after 50 pixels:
  - Immediately FILL with `data_valid=0`.
  - The next 300 pixels give `data_valid=1`, `k=0`.
